vm_restock_ctrl: RTL
====================

VM_RESTOCK_CTRL -- requirements
Module: vm_restock_ctrl

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 6, number of product slots (codes 1..NUM_SLOTS).
REQ-002 SHALL have parameter GAP, default 2, idle cycles inserted after each enter_key pulse.
REQ-003 SHALL have port clk  in  1  single clock, rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  in  1  operator restock request.
REQ-006 SHALL have port cmd_ready  out  1  controller accepts command this cycle.
REQ-007 SHALL have port cmd_add  in  1  1 = add to slot count, 0 = overwrite slot count.
REQ-008 SHALL have port cmd_slot  in  3  slot code 1..NUM_SLOTS.
REQ-009 SHALL have port cmd_count  in  4  item quantity.
REQ-010 SHALL have port cmd_cost  in  8  unit price.
REQ-011 SHALL have port valid_s  out  1  slot-programming strobe to vending machine.
REQ-012 SHALL have port items_s  out  3  slot code being programmed.
REQ-013 SHALL have port count_s  out  4  resulting slot count.
REQ-014 SHALL have port cost_s  out  8  slot price.
REQ-015 SHALL have port enter_key  out  1  commit pulse to vending machine.
REQ-016 SHALL have port product  in  3  dispensed slot code from vending machine, 0 = none.
REQ-017 SHALL have port status  in  2  vending machine status; 2'b01 = dispense done.
REQ-018 SHALL have port empty_mask  out  NUM_SLOTS  bit k-1 set when shadow count of slot k is 0.
REQ-019 SHALL have port err  out  1  one-cycle pulse on rejected command or dispense underflow.

Function
REQ-020 SHALL keep a shadow table per slot: count (4 bit), cost (8 bit).
REQ-021 SHALL implement FSM states IDLE, LOAD, COMMIT, GAP_WAIT.
REQ-022 IDLE: cmd_ready=1; on cmd_valid with valid slot, latch command, compute new count, go LOAD.
REQ-023 Slot code 0 or >NUM_SLOTS: cmd_ready=1 accepts it, table unchanged, err pulses next cycle, stay IDLE.
REQ-024 New count = cmd_count if cmd_add=0; shadow+cmd_count saturated at 15 if cmd_add=1.
REQ-025 LOAD (1 cycle): valid_s=1, items_s/count_s/cost_s = latched slot, new count, cmd_cost; go COMMIT.
REQ-026 COMMIT (1 cycle): valid_s=1, fields held, enter_key=1; shadow table written at end of cycle; go GAP_WAIT.
REQ-027 GAP_WAIT: valid_s=0, enter_key=0 for GAP cycles via down-counter, then IDLE.
REQ-028 cmd_ready SHALL be 0 in LOAD, COMMIT, GAP_WAIT; command-to-enter_key latency = 2 cycles.
REQ-029 items_s/count_s/cost_s SHALL be 0 whenever valid_s=0.
REQ-030 Dispense event: status==2'b01 and product in 1..NUM_SLOTS; decrements that slot's shadow count by 1, in any FSM state.
REQ-031 Dispense on slot with shadow count 0: count stays 0, err pulses next cycle.
REQ-032 Dispense and COMMIT to same slot in same cycle: result = new count minus 1, saturating at 0.
REQ-033 Dispense with product 0 or out-of-range: ignored, no err.
REQ-034 empty_mask SHALL be combinational from shadow counts.
REQ-035 err pulses from REQ-023 and REQ-031 in the same cycle SHALL merge into one pulse.

Reset
REQ-036 rst high at clk edge SHALL force IDLE, clear GAP counter, clear all shadow counts and costs.
REQ-037 During and after reset: valid_s=0, enter_key=0, items_s=0, count_s=0, cost_s=0, err=0, cmd_ready=1 after release, empty_mask all ones.
REQ-038 Reset asserted mid-sequence (LOAD/COMMIT/GAP_WAIT) SHALL abort without issuing enter_key; the command is lost.

Verification
REQ-039 Reset, then cmd slot=3, add=0, count=5, cost=20 -> valid_s cycles 1-2, enter_key cycle 2 with items_s=3,count_s=5,cost_s=20; cmd_ready low 4 cycles; empty_mask=6'b111011.
REQ-040 Slot 3 count=12, then add count=9 -> count_s=15 (saturated).
REQ-041 cmd_slot=7 -> no valid_s, err one pulse, table unchanged.
REQ-042 Slot 2 count=1; two dispenses product=2,status=01 -> count 0, second dispense pulses err, empty_mask bit1=1.
REQ-043 COMMIT slot 4 count=5 coinciding with dispense product=4 -> shadow count 4.
REQ-044 rst asserted during LOAD -> no enter_key, outputs zero next cycle, empty_mask all ones.

Source files
------------

// File: rtl/vm_restock_ctrl.sv
// Vending-machine restock controller.
// Accepts operator restock commands, shows each one to the vending machine
// as a two-cycle slot-programming strobe with a commit pulse, and keeps a
// shadow table of slot counts/prices that also tracks dispense events.
module vm_restock_ctrl #(
  parameter int NUM_SLOTS = 6,
  parameter int GAP       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_add,
  input  logic [2:0]           cmd_slot,
  input  logic [3:0]           cmd_count,
  input  logic [7:0]           cmd_cost,
  output logic                 valid_s,
  output logic [2:0]           items_s,
  output logic [3:0]           count_s,
  output logic [7:0]           cost_s,
  output logic                 enter_key,
  input  logic [2:0]           product,
  input  logic [1:0]           status,
  output logic [NUM_SLOTS-1:0] empty_mask,
  output logic                 err
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_GAP_WAIT} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [GW-1:0]  r_gap;
  logic [GW-1:0]  w_gap_nxt;

  // latched command (datapath only, qualified by the FSM state)
  logic [2:0]     r_slot;
  logic [3:0]     r_count;
  logic [7:0]     r_cost;

  // shadow table, entry k holds slot code k+1
  logic [3:0]     r_cnt_tab  [NUM_SLOTS];
  logic [7:0]     r_cost_tab [NUM_SLOTS];
  logic [3:0]     w_cnt_nxt  [NUM_SLOTS];

  logic           r_err;
  logic           w_slot_ok;
  logic           w_accept;
  logic           w_bad_cmd;
  logic           w_commit;
  logic           w_disp;
  logic           w_uflow;
  logic [3:0]     w_cur_cnt;
  logic [3:0]     w_new_cnt;

  function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4] ? 4'hF : s[3:0];
  endfunction

  function automatic logic [3:0] dec_sat(input logic [3:0] a);
    return (a == 4'd0) ? 4'd0 : a - 4'd1;
  endfunction

  assign w_slot_ok = (cmd_slot != 3'd0) && (int'(cmd_slot) <= NUM_SLOTS);
  assign w_accept  = (r_state == S_IDLE) && cmd_valid;
  assign w_bad_cmd = w_accept && !w_slot_ok;
  assign w_commit  = (r_state == S_COMMIT);
  assign w_disp    = (status == 2'b01) && (product != 3'd0) && (int'(product) <= NUM_SLOTS);
  assign w_new_cnt = cmd_add ? sat_add(w_cur_cnt, cmd_count) : cmd_count;
  assign err       = r_err;

  // Current shadow count of the slot addressed by the incoming command
  always_comb begin
    w_cur_cnt = 4'd0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (int'(cmd_slot) == k + 1) w_cur_cnt = r_cnt_tab[k];
    end
  end

  // Next shadow counts: commit overwrites first, a dispense then decrements the result
  always_comb begin
    logic [3:0] v_base;
    v_base  = 4'd0;
    w_uflow = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      v_base = (w_commit && int'(r_slot) == k + 1) ? r_count : r_cnt_tab[k];
      w_cnt_nxt[k] = v_base;
      if (w_disp && int'(product) == k + 1) begin
        if (v_base == 4'd0) w_uflow = 1'b1;
        w_cnt_nxt[k] = dec_sat(v_base);
      end
    end
  end

  // Empty flags straight from the shadow counts
  always_comb begin
    for (int k = 0; k < NUM_SLOTS; k++) begin
      empty_mask[k] = (r_cnt_tab[k] == 4'd0);
    end
  end

  // FSM state and gap counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

  // FSM next state and vending-machine interface outputs
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    cmd_ready   = 1'b0;
    valid_s     = 1'b0;
    enter_key   = 1'b0;
    items_s     = 3'd0;
    count_s     = 4'd0;
    cost_s      = 8'd0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && w_slot_ok) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        valid_s     = 1'b1;
        items_s     = r_slot;
        count_s     = r_count;
        cost_s      = r_cost;
        w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        valid_s   = 1'b1;
        enter_key = 1'b1;
        items_s   = r_slot;
        count_s   = r_count;
        cost_s    = r_cost;
        if (GAP == 0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_GAP_WAIT;
          w_gap_nxt   = GW'(GAP - 1);
        end
      end
      S_GAP_WAIT: begin
        if (r_gap == '0) w_state_nxt = S_IDLE;
        else             w_gap_nxt   = r_gap - 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch an accepted command; new count is resolved against the shadow now
  always_ff @(posedge clk) begin
    if (w_accept && w_slot_ok) begin
      r_slot  <= cmd_slot;
      r_count <= w_new_cnt;
      r_cost  <= cmd_cost;
    end
  end

  // Shadow table update from commits and dispenses
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        r_cnt_tab[k]  <= 4'd0;
        r_cost_tab[k] <= 8'd0;
      end
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        r_cnt_tab[k] <= w_cnt_nxt[k];
        if (w_commit && int'(r_slot) == k + 1) r_cost_tab[k] <= r_cost;
      end
    end
  end

  // Single merged error pulse for a rejected command or dispense underflow
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_bad_cmd | w_uflow;
  end

endmodule
